start_accept_responder: RTL and testbench

- Responder end of the start/cancel/accept handshake.
- Samples an initiator's `start` and returns a single-cycle `accept` no earlier than MIN_DELAY cycles later, gated by backend readiness.
- Abandons the transaction if `cancel` is seen, so a correct initiator/responder pair satisfies "!cancel throughout (start ##1 accept[->1])" and "start |-> !accept[*MIN_DELAY]".
- Keeps saturating accept/cancel statistics and a sticky protocol-error flag.

---
 rtl/start_accept_responder.sv | 102 ++++++++++
 tb/tb_start_accept_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/start_accept_responder.sv
// Responder side of the start/cancel/accept handshake with a minimum
// start-to-accept delay, backend gating and saturating statistics.
module start_accept_responder #(
    parameter int MIN_DELAY = 5,
    parameter int DELAY_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cancel,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic               ready_in,
    output logic               accept,
    output logic               busy,
    output logic               cancelled,
    output logic [CNT_W-1:0]   accept_count,
    output logic [CNT_W-1:0]   cancel_count,
    output logic               protocol_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;

    localparam logic [DELAY_W:0] MIN_D = (DELAY_W+1)'(MIN_DELAY);
    localparam logic [DELAY_W:0] ONE   = (DELAY_W+1)'(1);

    logic [1:0]       state;
    logic [DELAY_W:0] timer;
    logic [DELAY_W:0] cfg_ext;
    logic [DELAY_W:0] d_eff;
    logic [DELAY_W:0] load;
    logic             take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // One extra bit keeps the max() and the minus-one free of wraparound.
    always_comb begin
        cfg_ext = {1'b0, delay_cfg};
        d_eff   = (cfg_ext < MIN_D) ? MIN_D : cfg_ext;
        load    = d_eff - ONE;
        take    = start && !cancel;
    end

    assign accept = (state == ACC);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            cancelled    <= 1'b0;
            protocol_err <= 1'b0;
            accept_count <= '0;
            cancel_count <= '0;
        end else begin
            cancelled <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state <= WAIT;
                        timer <= load;
                    end
                end
                WAIT: begin
                    if (cancel) begin
                        state        <= IDLE;
                        cancelled    <= 1'b1;
                        cancel_count <= sat_inc(cancel_count);
                    end else begin
                        if (start)
                            protocol_err <= 1'b1;
                        if (timer != '0)
                            timer <= timer - ONE;
                        else if (ready_in)
                            state <= ACC;
                    end
                end
                ACC: begin
                    if (cancel) begin
                        cancelled    <= 1'b1;
                        cancel_count <= sat_inc(cancel_count);
                    end else begin
                        accept_count <= sat_inc(accept_count);
                    end
                    // A fresh start here chains straight into the next wait.
                    if (take) begin
                        state <= WAIT;
                        timer <= load;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_start_accept_responder.sv
// Randomized bench for start_accept_responder against a cycle-number
// reference model (deadline = start cycle + effective delay).
module tb_start_accept_responder;

    localparam int MIN_DELAY = 5;
    localparam int DELAY_W   = 8;
    localparam int CNT_W     = 2;
    localparam int SAT       = (1 << CNT_W) - 1;
    localparam int NCYC      = 3000;

    logic               clk;
    logic               rst;
    logic               start;
    logic               cancel;
    logic [DELAY_W-1:0] delay_cfg;
    logic               ready_in;
    logic               accept;
    logic               busy;
    logic               cancelled;
    logic [CNT_W-1:0]   accept_count;
    logic [CNT_W-1:0]   cancel_count;
    logic               protocol_err;

    start_accept_responder #(
        .MIN_DELAY(MIN_DELAY),
        .DELAY_W  (DELAY_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cancel      (cancel),
        .delay_cfg   (delay_cfg),
        .ready_in    (ready_in),
        .accept      (accept),
        .busy        (busy),
        .cancelled   (cancelled),
        .accept_count(accept_count),
        .cancel_count(cancel_count),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: transaction opened at cycle t0 with delay d may be
    // accepted by any cycle c with c - t0 >= d while ready_in is high.
    int c;
    bit m_open, m_acc, m_canc, m_err;
    int m_t0, m_d, m_ac, m_cc;

    function automatic int eff(input int cfg);
        return (cfg < MIN_DELAY) ? MIN_DELAY : cfg;
    endfunction

    function automatic int sat1(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        c = 0;
        m_open = 0; m_acc = 0; m_canc = 0; m_err = 0;
        m_t0 = 0; m_d = 0; m_ac = 0; m_cc = 0;
    endtask

    task automatic model_step();
        bit nx_acc = 0;
        bit nx_canc = 0;
        if (m_acc) begin
            if (cancel) begin
                m_cc = sat1(m_cc);
                nx_canc = 1;
            end else begin
                m_ac = sat1(m_ac);
            end
            if (start && !cancel) begin
                m_open = 1; m_t0 = c; m_d = eff(int'(delay_cfg));
            end else begin
                m_open = 0;
            end
        end else if (m_open) begin
            if (cancel) begin
                m_open = 0;
                nx_canc = 1;
                m_cc = sat1(m_cc);
            end else begin
                if (start) m_err = 1;
                if ((c - m_t0) >= m_d && ready_in) begin
                    m_open = 0;
                    nx_acc = 1;
                end
            end
        end else if (start && !cancel) begin
            m_open = 1; m_t0 = c; m_d = eff(int'(delay_cfg));
        end
        m_acc = nx_acc;
        m_canc = nx_canc;
        c++;
    endtask

    task automatic check_all(input string ph);
        chk({ph, " accept"}, int'(accept), int'(m_acc));
        chk({ph, " busy"}, int'(busy), int'(m_open || m_acc));
        chk({ph, " cancelled"}, int'(cancelled), int'(m_canc));
        chk({ph, " accept_count"}, int'(accept_count), m_ac);
        chk({ph, " cancel_count"}, int'(cancel_count), m_cc);
        chk({ph, " protocol_err"}, int'(protocol_err), int'(m_err));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        delay_cfg = '0;
        ready_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");
        for (int i = 0; i < NCYC; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check_all("run");
            end
            if (i % 400 == 399) begin
                // Asynchronous reset between edges must clear outputs at once.
                rst = 1'b1;
                #1;
                model_reset();
                check_all("async_rst");
                @(negedge clk);
                rst = 1'b0;
                check_all("post_rst");
            end
            if (i < 40) begin
                // Directed: single start at cycle 10 with delay_cfg=0.
                start = (i == 10);
                cancel = 1'b0;
                delay_cfg = '0;
                ready_in = 1'b1;
            end else begin
                start = ($urandom_range(0, 99) < 30);
                cancel = ($urandom_range(0, 99) < 7);
                ready_in = ($urandom_range(0, 99) < 70);
                delay_cfg = ($urandom_range(0, 19) == 0) ?
                            DELAY_W'($urandom_range(13, 40)) :
                            DELAY_W'($urandom_range(0, 12));
            end
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        check_all("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
